// File: rtl/uart_cmd_ctrl.sv
// Byte-command sequencer: parses UART commands, commits glitch delay/width config,
// pulses arm, and hands one response byte per command to the transmitter (valid/ready).
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 5_000_000,
  parameter logic [15:0] DELAY_RST    = 16'd0,
  parameter logic [7:0]  WIDTH_RST    = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  status_i,
  output logic [15:0] delay_o,
  output logic [7:0]  width_o,
  output logic        arm_o,
  output logic        busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS);

  localparam logic [7:0] CMD_DELAY   = 8'h64;
  localparam logic [7:0] CMD_WIDTH   = 8'h77;
  localparam logic [7:0] CMD_ARM     = 8'h61;
  localparam logic [7:0] CMD_RESTORE = 8'h72;
  localparam logic [7:0] CMD_STATUS  = 8'h73;
  localparam logic [7:0] RSP_OK      = 8'h6B;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h74;

  typedef enum logic [1:0] {IDLE, PAYLOAD, EXEC, RESP} state_t;

  state_t        state;
  logic [7:0]    opcode;
  logic [1:0]    remaining;
  logic [15:0]   shift;
  logic [TW-1:0] timer;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      opcode     <= 8'h00;
      remaining  <= 2'd0;
      shift      <= 16'h0000;
      timer      <= '0;
      delay_o    <= DELAY_RST;
      width_o    <= WIDTH_RST;
      arm_o      <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      arm_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            opcode <= rx_data_i;
            case (rx_data_i)
              CMD_DELAY, CMD_WIDTH: begin
                state     <= PAYLOAD;
                remaining <= (rx_data_i == CMD_DELAY) ? 2'd2 : 2'd1;
                shift     <= 16'h0000;
                timer     <= '0;
              end
              CMD_ARM, CMD_RESTORE, CMD_STATUS: state <= EXEC;
              default: begin
                tx_data_o  <= RSP_UNKNOWN;
                tx_valid_o <= 1'b1;
                state      <= RESP;
              end
            endcase
          end
        end

        PAYLOAD: begin
          // A byte landing on the timeout cycle still counts as payload.
          if (rx_valid_i) begin
            shift     <= {shift[7:0], rx_data_i};
            remaining <= remaining - 2'd1;
            timer     <= '0;
            if (remaining == 2'd1) state <= EXEC;
          end else begin
            if (timer != TMAX) timer <= timer + TW'(1);
            if (timer >= TMAX - TW'(1)) begin
              tx_data_o  <= RSP_TIMEOUT;
              tx_valid_o <= 1'b1;
              state      <= RESP;
            end
          end
        end

        EXEC: begin
          tx_data_o <= RSP_OK;
          case (opcode)
            CMD_DELAY:   delay_o <= shift;
            CMD_WIDTH:   width_o <= shift[7:0];
            CMD_ARM:     arm_o   <= 1'b1;
            CMD_RESTORE: begin
              delay_o <= DELAY_RST;
              width_o <= WIDTH_RST;
            end
            CMD_STATUS:  tx_data_o <= status_i;
            default: ;
          endcase
          tx_valid_o <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          if (tx_valid_o && tx_ready_i) begin
            tx_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected response bytes are queued as commands are
// sent and compared when the transmitter handshake occurs.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  status;
  logic [15:0] delay;
  logic [7:0]  width;
  logic        arm;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int arm_cnt = 0;
  logic [7:0] exp_q[$];

  uart_cmd_ctrl #(.TIMEOUT_CLKS(100), .DELAY_RST(16'd0), .WIDTH_RST(8'd1)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .status_i(status),
    .delay_o(delay), .width_o(width), .arm_o(arm), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after posedge, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
      else chk("resp_byte", tx_data, exp_q.pop_front());
    end
    if (!rst && arm) arm_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || tx_valid) && n < 50) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int arm0;
    int bad;
    int cnt;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; status = 8'h00;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_delay", delay, 16'h0000);
    chk("rst_width", width, 8'h01);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arm", arm, 0);
    chk("rst_tx_data", tx_data, 8'h00);

    // Delay write, ready held high
    tx_ready = 1'b1;
    exp_q.push_back(8'h6B);
    send_byte(8'h64); send_byte(8'h12); send_byte(8'h34);
    chk("delay_early", delay, 16'h0000);
    step();
    chk("delay_commit", delay, 16'h1234);
    chk("delay_width_kept", width, 8'h01);
    wait_idle("delay_idle");

    // Arm with 20 cycles of backpressure
    tx_ready = 1'b0;
    arm0 = arm_cnt;
    exp_q.push_back(8'h6B);
    send_byte(8'h61);
    chk("arm_early", arm, 0);
    step();
    chk("arm_pulse", arm, 1);
    chk("arm_tx_valid", tx_valid, 1);
    chk("arm_tx_data", tx_data, 8'h6B);
    step();
    chk("arm_pulse_end", arm, 0);
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (!(tx_valid === 1'b1 && tx_data === 8'h6B)) bad++;
    end
    chk("resp_hold", bad, 0);
    chk("busy_under_bp", busy, 1);
    tx_ready = 1'b1;
    step();
    chk("arm_accepted_busy", busy, 0);
    chk("arm_accepted_valid", tx_valid, 0);
    chk("arm_count", arm_cnt - arm0, 1);

    // Unknown command, then a dropped byte while the response is pending
    tx_ready = 1'b0;
    arm0 = arm_cnt;
    exp_q.push_back(8'h3F);
    send_byte(8'h55);
    chk("unk_latency", tx_valid, 1);
    chk("unk_data", tx_data, 8'h3F);
    send_byte(8'h61);
    repeat (3) step();
    tx_ready = 1'b1;
    step();
    repeat (5) step();
    chk("drop_no_arm", arm_cnt - arm0, 0);
    chk("drop_idle_busy", busy, 0);
    chk("drop_idle_valid", tx_valid, 0);

    // Width payload timeout after 100 idle clocks
    exp_q.push_back(8'h74);
    send_byte(8'h77);
    cnt = 0;
    while (!tx_valid && cnt < 200) begin
      step();
      cnt++;
    end
    chk("timeout_latency", cnt, 100);
    chk("timeout_data", tx_data, 8'h74);
    wait_idle("timeout_idle");
    chk("timeout_width_kept", width, 8'h01);

    exp_q.push_back(8'h6B);
    send_byte(8'h77); send_byte(8'hA5);
    step();
    chk("width_commit", width, 8'hA5);
    wait_idle("width_idle");

    // Status snapshot and restore
    exp_q.push_back(8'h6B);
    send_byte(8'h64); send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("beef_idle");
    chk("delay_beef", delay, 16'hBEEF);
    status = 8'h5A;
    exp_q.push_back(8'h5A);
    send_byte(8'h73);
    wait_idle("status_idle");
    exp_q.push_back(8'h6B);
    send_byte(8'h72);
    wait_idle("restore_idle");
    chk("restore_delay", delay, 16'h0000);
    chk("restore_width", width, 8'h01);

    // Reset in the middle of a delay frame
    exp_q.push_back(8'h6B);
    send_byte(8'h64); send_byte(8'h11); send_byte(8'h11);
    wait_idle("pre_rst_idle");
    chk("pre_rst_delay", delay, 16'h1111);
    send_byte(8'h64); send_byte(8'h12);
    chk("mid_frame_busy", busy, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst_delay", delay, 16'h0000);
    chk("midrst_width", width, 8'h01);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 8'h00);
    repeat (10) step();
    chk("midrst_no_resp", tx_valid, 0);
    chk("midrst_still_idle", busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receive path and the glitcher's configuration. It consumes one-cycle byte strobes from the UART receiver and parses single-byte commands, some followed by payload bytes. It commits the glitch delay and width registers, issues arm pulses, and queues one response byte per command to a UART transmitter through a valid/ready handshake.

Parameters:
TIMEOUT_CLKS, 5_000_000, max idle clocks between payload bytes before the frame is abandoned (100 ms at 50 MHz).
DELAY_RST, 16'd0, reset/default value of delay_o.
WIDTH_RST, 8'd1, reset/default value of width_o.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
rx_data_i  input  8  received byte; valid only when rx_valid_i=1
rx_valid_i  input  1  one-cycle strobe, byte present
tx_data_o  output  8  response byte
tx_valid_o  output  1  response pending; held until accepted
tx_ready_i  input  1  transmitter accepts byte when tx_valid_o&tx_ready_i
status_i  input  8  glitcher status, snapshotted for 's' command
delay_o  output  16  glitch delay config
width_o  output  8  glitch pulse width config
arm_o  output  1  one-cycle arm pulse
busy_o  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: delay_o=DELAY_RST, width_o=WIDTH_RST, arm_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, state=IDLE, payload count=0, shift register=0, timer=0.
- Command set (byte values):
  - 0x64 'd': 2 payload bytes, MSB first, load into delay_o.
  - 0x77 'w': 1 payload byte, load into width_o.
  - 0x61 'a': pulse arm_o.
  - 0x72 'r': restore delay_o/width_o to their defaults.
  - 0x73 's': respond with status_i.
  - Any other byte: unknown.
- Responses: 0x6B 'k' on success for d/w/a/r; the status_i snapshot for s; 0x3F '?' for unknown; 0x74 't' on timeout.
- States: IDLE, PAYLOAD, EXEC, RESP.
- IDLE, on rx_valid_i:
  - d/w: go to PAYLOAD; remaining = 2 or 1; shift register cleared; timer cleared; opcode latched.
  - a/r/s: go to EXEC.
  - Unknown: go to RESP with tx_data_o=0x3F, tx_valid_o=1.
- PAYLOAD:
  - On rx_valid_i: shift register <= {shift[7:0], rx_data_i}; remaining decrements; timer clears. The last byte transitions to EXEC.
  - Without rx_valid_i: timer increments. When timer reaches TIMEOUT_CLKS, go to RESP with tx_data_o=0x74. No config is written and partial payload is discarded.
  - rx_valid_i in the same cycle as the timeout is accepted as a payload byte; it takes precedence and the timer clears.
- EXEC (exactly one cycle), commits per latched opcode:
  - delay_o <= shift[15:0], or width_o <= shift[7:0], or arm_o=1 for this one cycle, or defaults restored, or tx_data_o <= status_i.
  - tx_data_o is loaded and tx_valid_o set on the same edge; next state RESP.
- Latency: command/last-payload byte strobed in cycle N. Config update, arm_o pulse and tx_valid_o all become visible in cycle N+2. Unknown-command tx_valid_o becomes visible in cycle N+1.
- RESP:
  - tx_valid_o and tx_data_o are held stable until tx_valid_o&tx_ready_i is sampled.
  - On that edge tx_valid_o=0 and state returns to IDLE. A new command byte is accepted from the following cycle.
  - tx_ready_i is ignored while tx_valid_o=0.
- Dropped bytes: rx_valid_i in EXEC or RESP is dropped, with no state effect. The host must wait for each response.
- Width rules:
  - Timer width is $clog2(TIMEOUT_CLKS+1) and it saturates at TIMEOUT_CLKS.
  - Payload count is 2 bits.
  - Shift register is 16 bits; for 'w' only the low byte is used.
- Config registers change only in EXEC or reset and are otherwise stable.
- Reset mid-operation: immediate return to reset values. A pending response is cancelled and a partial frame is discarded.

Test Plan:
- Post-reset: no stimulus → delay_o=0x0000, width_o=0x01, tx_valid_o=0, busy_o=0.
- Delay write: bytes 0x64,0x12,0x34 with tx_ready_i=1 → delay_o=0x1234 two cycles after the third strobe; one response 0x6B; width_o unchanged.
- Arm with backpressure: byte 0x61, tx_ready_i=0 for 20 cycles then 1 → arm_o high exactly one cycle at N+2; tx_data_o=0x6B held for 20 cycles; busy_o drops after acceptance.
- Unknown and dropped: byte 0x55, then byte 0x61 while tx_valid_o=1 → response 0x3F only; no arm_o pulse; idle afterwards.
- Timeout (TIMEOUT_CLKS=100): bytes 0x77 then silence → after 100 clocks response 0x74; width_o stays 0x01. Repeat with 0x77,0xA5 → width_o=0xA5, response 0x6B.
- Status and restore:
  - Write delay 0xBEEF, then send 0x73 with status_i=0x5A → response 0x5A.
  - Send 0x72 → delay_o=0x0000, width_o=0x01, response 0x6B.
  - Assert rst mid-'d' frame → outputs return to reset values; no response.
